ahb_lite_single_master: RTL and testbench

AHB-Lite initiator that converts a simple one-at-a-time command/response interface into single NONSEQ AHB transfers. It drives address and control, handles slave wait states and the two-cycle ERROR response, and returns read data or error status. It sits between the subsystem's test/boot sequencer and the AHB fabric, and is the requesting side for slaves such as the ROM responder.

---
 rtl/ahb_master_pkg.sv | 39 +++
 rtl/ahb_wait_timer.sv | 32 +++
 rtl/ahb_lite_single_master.sv | 112 +++++++++++
 tb/tb_ahb_lite_single_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_master_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the single-master initiator.
package ahb_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_LERR = 2'd3
  } state_t;

  // Size must fit the 32-bit bus and the address must be naturally aligned.
  function automatic logic cmd_is_legal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      HSIZE_BYTE: ok = 1'b1;
      HSIZE_HALF: ok = ~addr_lo[0];
      HSIZE_WORD: ok = (addr_lo == 2'b00);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_wait_timer.sv
// Saturating data-phase wait counter with a sticky threshold flag.
module ahb_wait_timer #(
  parameter int unsigned THRESHOLD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout_flag
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      timeout_flag <= 1'b0;
    end else if (clear) begin
      count        <= '0;
      timeout_flag <= 1'b0;
    end else if (enable) begin
      count <= count_inc;
      if (count_inc >= CNT_W'(THRESHOLD)) timeout_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/ahb_lite_single_master.sv
// Command/response to single NONSEQ AHB-Lite transfer initiator.
module ahb_lite_single_master
  import ahb_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              timeout_flag,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic [1:0]        hresp
);

  state_t            state;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              wait_en;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign wait_en   = (state == ST_DATA) & ~hready;
  assign hburst    = HBURST_SINGLE;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      htrans    <= HTRANS_IDLE;
      haddr     <= '0;
      hwrite    <= 1'b0;
      hsize     <= '0;
      hwdata    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_is_legal(cmd_size, cmd_addr[1:0])) begin
              state   <= ST_ADDR;
              htrans  <= HTRANS_NONSEQ;
              haddr   <= cmd_addr;
              hwrite  <= cmd_write;
              hsize   <= cmd_size;
              wdata_q <= cmd_wdata;
            end else begin
              // Local reject answers immediately and never touches the bus.
              state     <= ST_LERR;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end
        ST_LERR: state <= ST_IDLE;
        ST_ADDR: begin
          if (hready) begin
            state  <= ST_DATA;
            htrans <= HTRANS_IDLE;
            hwdata <= wdata_q;
          end
        end
        ST_DATA: begin
          if (hready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            // Any non-OKAY response, including RETRY/SPLIT, ends as an error.
            if (hresp != HRESP_OKAY) begin
              rsp_error <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              rsp_error <= 1'b0;
              rsp_rdata <= hwrite ? '0 : hrdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ahb_wait_timer #(
    .THRESHOLD(TIMEOUT)
  ) u_wait_timer (
    .clk          (hclk),
    .reset        (hreset),
    .clear        (accept),
    .enable       (wait_en),
    .timeout_flag (timeout_flag)
  );

endmodule

// File: tb/tb_ahb_lite_single_master.sv
// Randomized scoreboard bench for ahb_lite_single_master with a behavioural slave.
module tb_ahb_lite_single_master;
  import ahb_master_pkg::*;

  localparam int unsigned TO = 16;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        timeout_flag;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  ahb_lite_single_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .timeout_flag(timeout_flag),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  int unsigned cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic        chk_rdata;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic flag_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge hclk) begin : monitor
    exp_t e;
    if (!hreset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid want none (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_cycle", cyc, e.cyc);
        chk("rsp_error", 32'(rsp_error), 32'(e.err));
        if (e.chk_rdata) chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
  end

  task automatic bus_idle();
    hready = 1'b1;
    hresp  = HRESP_OKAY;
    hrdata = $urandom;
  endtask

  // Issue one command from an idle DUT, play the slave, and push the expected response.
  // mode: 0 OKAY, 1 two-cycle ERROR, 2 single-cycle ERROR, 3 RETRY/SPLIT.
  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wd, input int aw, input int w, input int mode,
                        input logic [31:0] rd);
    logic legal;
    logic err;
    exp_t e;
    legal = (size == 3'd0) || (size == 3'd1 && addr[0] == 1'b0) ||
            (size == 3'd2 && addr[1:0] == 2'b00);
    err   = !legal || (mode != 0);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    chk("timeout_sticky", 32'(timeout_flag), 32'(flag_model));
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wd;
    e.err       = err;
    e.chk_rdata = err || !wr;
    e.rdata     = err ? 32'd0 : rd;
    e.cyc       = cyc + 1 + (legal ? 32'(2 + aw + w) : 32'd0);
    exp_q.push_back(e);
    @(negedge hclk);
    flag_model = 1'b0;
    chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
    chk("timeout_clear", 32'(timeout_flag), 32'd0);
    // A busy DUT must ignore whatever the requester presents.
    if ($urandom_range(0, 1) == 1) begin
      cmd_write = 1'($urandom);
      cmd_addr  = $urandom & 32'hFFFF_FFFC;
      cmd_size  = HSIZE_WORD;
    end else begin
      cmd_valid = 1'b0;
    end
    if (!legal) begin
      chk("htrans_reject", 32'(htrans), 32'(HTRANS_IDLE));
      @(negedge hclk);
      cmd_valid = 1'b0;
      chk("htrans_after_reject", 32'(htrans), 32'(HTRANS_IDLE));
    end else begin
      chk("htrans_nonseq", 32'(htrans), 32'(HTRANS_NONSEQ));
      chk("haddr", haddr, addr);
      chk("hwrite", 32'(hwrite), 32'(wr));
      chk("hsize", 32'(hsize), 32'(size));
      for (int i = 0; i < aw; i++) begin
        hready = 1'b0;
        hresp  = HRESP_OKAY;
        @(negedge hclk);
        chk("htrans_addr_hold", 32'(htrans), 32'(HTRANS_NONSEQ));
        chk("haddr_hold", haddr, addr);
      end
      hready = 1'b1;
      @(negedge hclk);
      for (int i = 0; i < w; i++) begin
        chk("htrans_data", 32'(htrans), 32'(HTRANS_IDLE));
        if (wr) chk("hwdata_wait", hwdata, wd);
        chk("timeout_wait", 32'(timeout_flag), 32'(i >= int'(TO)));
        hready = 1'b0;
        hresp  = (mode == 1 && i == w - 1) ? HRESP_ERROR : HRESP_OKAY;
        hrdata = $urandom;
        @(negedge hclk);
      end
      chk("htrans_data_last", 32'(htrans), 32'(HTRANS_IDLE));
      if (wr) chk("hwdata_last", hwdata, wd);
      chk("timeout_last", 32'(timeout_flag), 32'(w >= int'(TO)));
      hready = 1'b1;
      case (mode)
        0:       hresp = HRESP_OKAY;
        3:       hresp = 2'($urandom_range(2, 3));
        default: hresp = HRESP_ERROR;
      endcase
      hrdata = rd;
      @(negedge hclk);
      cmd_valid  = 1'b0;
      bus_idle();
      flag_model = (w >= int'(TO));
      chk("timeout_after", 32'(timeout_flag), 32'(flag_model));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    int          r, w, mode;
    hreset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;
    bus_idle();
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_hsize", 32'(hsize), 32'd0);
    chk("rst_hburst", 32'(hburst), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_timeout", 32'(timeout_flag), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    hreset = 1'b0;
    @(negedge hclk);

    do_cmd(1'b0, 32'h0000_0100, HSIZE_WORD, 32'h0, 0, 0, 0, 32'hDEAD_BEEF);
    do_cmd(1'b1, 32'h0000_0008, HSIZE_WORD, 32'h1234_5678, 0, 2, 0, 32'h0);
    do_cmd(1'b1, 32'h0000_0010, HSIZE_WORD, 32'hCAFE_F00D, 0, 1, 1, 32'h0);
    do_cmd(1'b0, 32'h0000_0020, HSIZE_HALF, 32'h0, 1, 0, 2, 32'h5555_AAAA);
    do_cmd(1'b0, 32'h0000_0004, 3'b011, 32'h0, 0, 0, 0, 32'h0);
    do_cmd(1'b0, 32'h0000_0002, HSIZE_WORD, 32'h0, 0, 0, 0, 32'h0);
    do_cmd(1'b0, 32'h0000_0003, HSIZE_HALF, 32'h0, 0, 0, 0, 32'h0);
    do_cmd(1'b0, 32'h0000_0200, HSIZE_WORD, 32'h0, 0, 20, 0, 32'h0BAD_F00D);
    do_cmd(1'b0, 32'h0000_0007, HSIZE_BYTE, 32'h0, 0, 15, 3, 32'h0);

    // Reset while the data phase is stalled: the transfer must vanish silently.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0040;
    cmd_size  = HSIZE_WORD;
    cmd_wdata = 32'hFFFF_0000;
    @(negedge hclk);
    cmd_valid = 1'b0;
    @(negedge hclk);
    hready = 1'b0;
    @(negedge hclk);
    hreset = 1'b1;
    @(negedge hclk);
    chk("mid_rst_htrans", 32'(htrans), 32'd0);
    chk("mid_rst_haddr", haddr, 32'd0);
    chk("mid_rst_hwdata", hwdata, 32'd0);
    chk("mid_rst_hwrite", 32'(hwrite), 32'd0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    hreset = 1'b0;
    bus_idle();
    flag_model = 1'b0;
    @(negedge hclk);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    do_cmd(1'b0, 32'h0000_0044, HSIZE_WORD, 32'h0, 0, 0, 0, 32'h7777_1111);

    for (int n = 0; n < 150; n++) begin
      wr = 1'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 2)      size = HSIZE_BYTE;
      else if (r < 4) size = HSIZE_HALF;
      else if (r < 9) size = HSIZE_WORD;
      else            size = 3'($urandom_range(3, 7));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == HSIZE_HALF) addr[0] = 1'b0;
        if (size == HSIZE_WORD) addr[1:0] = 2'b00;
      end
      w    = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 19) : $urandom_range(0, 3);
      mode = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      do_cmd(wr, addr, size, $urandom, $urandom_range(0, 2), w, mode, $urandom);
    end

    repeat (3) @(negedge hclk);
    chk("pending_rsp", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
